// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types used by the bus bridges and slaves.
// Widths follow the 32-bit Ibex memory map.
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [2:0]  prot_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite AW/W/B/AR/R channel bundle.
// master drives requests, slave drives responses.
interface axi4l_if;
  import axi4l_pkg::*;

  logic  awvalid;
  logic  awready;
  addr_t awaddr;
  prot_t awprot;

  logic  wvalid;
  logic  wready;
  data_t wdata;
  strb_t wstrb;

  logic  bvalid;
  logic  bready;
  resp_t bresp;

  logic  arvalid;
  logic  arready;
  addr_t araddr;
  prot_t arprot;

  logic  rvalid;
  logic  rready;
  data_t rdata;
  resp_t rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/ibex_mem_to_axi4l.sv
// Ibex req/gnt/rvalid memory port to AXI4-Lite master bridge.
// One transaction in flight; instruction-port writes fault locally.
module ibex_mem_to_axi4l
  import axi4l_pkg::*;
#(
  parameter bit INSTR_PORT = 1'b0
) (
  input  logic    aclk,
  input  logic    aresetn,
  input  logic    req_i,
  output logic    gnt_o,
  input  logic    we_i,
  input  strb_t   be_i,
  input  addr_t   addr_i,
  input  data_t   wdata_i,
  output logic    rvalid_o,
  output data_t   rdata_o,
  output logic    err_o,
  axi4l_if.master axi
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RRESP,
    LERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:2] waddr_q, waddr_d;
  data_t       wdata_q, wdata_d;
  strb_t       be_q, be_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  data_t       rdata_q, rdata_d;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    gnt_o       = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i & aresetn;
        if (req_i) begin
          waddr_d   = addr_i[31:2];
          wdata_d   = wdata_i;
          be_d      = be_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!we_i) begin
            state_d = READ;
          end else if (INSTR_PORT) begin
            // fetch port never writes: fault without touching the bus
            state_d  = LERR;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
        aw_done_d   = aw_done_q | axi.awready;
        w_done_d    = w_done_q | axi.wready;
        if (aw_done_d && w_done_d) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = (axi.bresp != OKAY);
        end
      end
      READ: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          state_d = RRESP;
        end
      end
      RRESP: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = axi.rdata;
          err_d    = (axi.rresp != OKAY);
        end
      end
      LERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign axi.awaddr = {waddr_q, 2'b00};
  assign axi.araddr = {waddr_q, 2'b00};
  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = be_q;
  assign axi.awprot = 3'b000;
  assign axi.arprot = INSTR_PORT ? 3'b100 : 3'b000;

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_ibex_mem_to_axi4l.sv
// Bench for ibex_mem_to_axi4l: AXI4-Lite RAM slave with wait/error knobs,
// reference word memory, directed and random Ibex transactions.
module tb_ibex_mem_to_axi4l;
  import axi4l_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic        req_i, we_i, gnt_o, rvalid_o, err_o;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i, rdata_o;

  logic        req2, we2, gnt2, rvalid2, err2;
  logic [3:0]  be2;
  logic [31:0] addr2, wdata2, rdata2;

  axi4l_if axi();
  axi4l_if axi2();

  ibex_mem_to_axi4l #(.INSTR_PORT(1'b0)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_i(req_i), .gnt_o(gnt_o),
    .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .axi(axi.master)
  );

  ibex_mem_to_axi4l #(.INSTR_PORT(1'b1)) dut_i (
    .aclk(aclk), .aresetn(aresetn), .req_i(req2), .gnt_o(gnt2),
    .we_i(we2), .be_i(be2), .addr_i(addr2), .wdata_i(wdata2),
    .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2),
    .axi(axi2.master)
  );

  // instruction-port slave never responds; any request on it is a fault
  assign axi2.awready = 1'b0;
  assign axi2.wready  = 1'b0;
  assign axi2.bvalid  = 1'b0;
  assign axi2.bresp   = OKAY;
  assign axi2.arready = 1'b0;
  assign axi2.rvalid  = 1'b0;
  assign axi2.rdata   = '0;
  assign axi2.rresp   = OKAY;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- AXI4-Lite RAM slave ----------------
  int aw_lat = 0, w_lat = 0, ar_lat = 0;
  bit b_err = 0, r_err = 0;
  int aw_cnt, w_cnt, ar_cnt;
  int aw_out = 0, ar_out = 0, max_out = 0, viol = 0;
  logic aw_got, w_got;
  logic [31:0] aw_a, w_d, last_awaddr, last_araddr, p_wd, p_awa;
  logic [3:0]  w_s, last_wstrb;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] mem [16];
  logic pl_en = 1'b0;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  wire aw_hs = axi.awvalid && axi.awready;
  wire w_hs  = axi.wvalid && axi.wready;
  wire b_hs  = axi.bvalid && axi.bready;
  wire ar_hs = axi.arvalid && axi.arready;
  wire r_hs  = axi.rvalid && axi.rready;

  assign axi.awready = axi.awvalid && !aw_got && aw_cnt >= aw_lat;
  assign axi.wready  = axi.wvalid && !w_got && w_cnt >= w_lat;
  assign axi.arready = axi.arvalid && !axi.rvalid && ar_cnt >= ar_lat;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  always @(posedge aclk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      axi.bvalid <= 1'b0; axi.bresp <= OKAY;
      axi.rvalid <= 1'b0; axi.rresp <= OKAY; axi.rdata <= '0;
      aw_out <= 0; ar_out <= 0;
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0;
      p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin
        aw_got <= 1'b1; aw_a <= axi.awaddr; last_awaddr <= axi.awaddr;
      end
      if (w_hs) begin
        w_got <= 1'b1; w_d <= axi.wdata; w_s <= axi.wstrb; last_wstrb <= axi.wstrb;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !axi.bvalid) begin
        if (!b_err)
          mem[aw_hs ? axi.awaddr[5:2] : aw_a[5:2]] <=
            merge(mem[aw_hs ? axi.awaddr[5:2] : aw_a[5:2]],
                  w_hs ? axi.wdata : w_d, w_hs ? axi.wstrb : w_s);
        axi.bvalid <= 1'b1;
        axi.bresp  <= b_err ? SLVERR : OKAY;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_hs) axi.bvalid <= 1'b0;
      if (ar_hs) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= mem[axi.araddr[5:2]];
        axi.rresp  <= r_err ? SLVERR : OKAY;
        last_araddr <= axi.araddr;
      end
      if (r_hs) axi.rvalid <= 1'b0;
      aw_out <= aw_out + (aw_hs ? 1 : 0) - (b_hs ? 1 : 0);
      ar_out <= ar_out + (ar_hs ? 1 : 0) - (r_hs ? 1 : 0);
      if (aw_out > max_out) max_out <= aw_out;
      if (ar_out > max_out) max_out <= ar_out;
      if ((aw_got && axi.awvalid) || (w_got && axi.wvalid) ||
          (p_awv && !p_awr && (!axi.awvalid || axi.awaddr != p_awa)) ||
          (p_wv && !p_wr && (!axi.wvalid || axi.wdata != p_wd)) ||
          (p_arv && !p_arr && !axi.arvalid))
        viol <= viol + 1;
      p_awv <= axi.awvalid; p_awr <= axi.awready; p_awa <= axi.awaddr;
      p_wv <= axi.wvalid; p_wr <= axi.wready; p_wd <= axi.wdata;
      p_arv <= axi.arvalid; p_arr <= axi.arready;
    end
  end

  // ---------------- response monitors ----------------
  logic [32:0] rsp_q[$];
  int rsp_c[$];
  int rsp_n = 0;
  int rsp2_n = 0;
  bit bus2_seen = 0;

  always @(negedge aclk) begin
    if (aresetn && rvalid_o) begin
      rsp_q.push_back({err_o, rdata_o});
      rsp_c.push_back(cyc);
      rsp_n <= rsp_n + 1;
    end
    if (aresetn && rvalid2) rsp2_n <= rsp2_n + 1;
    if (axi2.awvalid || axi2.wvalid || axi2.arvalid) bus2_seen <= 1'b1;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd = '0;

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge aclk);
    pl_en = 1'b1; pl_idx = idx[3:0]; pl_val = v;
    ref_mem[idx] = v;
    @(posedge aclk); #1;
    pl_en = 1'b0;
  endtask

  task automatic txn(input bit we, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, input int exp_lat, input string tag);
    int n0, k, g;
    logic [31:0] exp_d;
    bit exp_e;
    n0 = rsp_n;
    exp_e = we ? b_err : r_err;
    exp_d = we ? last_rd : ref_mem[a[5:2]];
    @(negedge aclk);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = a; wdata_i = wd;
    #1;
    k = 0;
    while (!gnt_o && k < 20) begin @(negedge aclk); #1; k++; end
    chk({tag, ":gnt"}, 32'(gnt_o), 32'd1);
    g = cyc;
    @(posedge aclk); #1;
    req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
    k = 0;
    while (rsp_n == n0 && k < 60) begin @(negedge aclk); #1; k++; end
    chk({tag, ":rsp"}, 32'(rsp_n - n0), 32'd1);
    if (rsp_n > n0) begin
      chk({tag, ":rdata"}, rsp_q[n0][31:0], exp_d);
      chk({tag, ":err"}, 32'(rsp_q[n0][32]), 32'(exp_e));
      if (exp_lat > 0) chk({tag, ":lat"}, 32'(rsp_c[n0] - g), 32'(exp_lat));
      if (we) begin
        chk({tag, ":awaddr"}, last_awaddr, {a[31:2], 2'b00});
        chk({tag, ":wstrb"}, 32'(last_wstrb), 32'(be));
      end else begin
        chk({tag, ":araddr"}, last_araddr, {a[31:2], 2'b00});
      end
    end
    repeat (2) @(negedge aclk);
    #1;
    chk({tag, ":single"}, 32'(rsp_n - n0), 32'd1);
    if (we && !b_err) ref_write(a, wd, be);
    if (!we) last_rd = exp_d;
  endtask

  initial begin
    int n0, k, idx;
    bit w;
    logic [31:0] a, wd, e_d [4];
    logic [3:0] be;

    aresetn = 1'b0;
    req_i = 1'b1; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
    req2 = 1'b0; we2 = 1'b0; be2 = '0; addr2 = '0; wdata2 = '0;
    #1;
    chk("rst:gnt", 32'(gnt_o), 32'd0);
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    preload(2, 32'hDEADBEEF);
    preload(1, 32'h11223344);
    chk("rst:rvalid", 32'(rvalid_o), 32'd0);
    chk("rst:err", 32'(err_o), 32'd0);
    chk("rst:rdata", rdata_o, 32'd0);
    chk("rst:valids", {29'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
    chk("rst:readies", {30'd0, axi.bready, axi.rready}, 32'd0);
    req_i = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;

    txn(1'b0, 4'hF, 32'h0000_0009, '0, 3, "read9");
    txn(1'b1, 4'b0010, 32'h0000_0004, 32'h0000_AB00, 3, "bytewr");
    txn(1'b0, 4'hF, 32'h0000_0004, '0, 3, "rdback");
    chk("rdback:const", last_rd, 32'h1122AB44);

    w_lat = 3;
    txn(1'b1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 6, "skew");
    w_lat = 0;
    chk("skew:viol", 32'(viol), 32'd0);

    // back-to-back with req held high
    n0 = rsp_n;
    @(negedge aclk);
    for (int i = 0; i < 4; i++) begin
      w = i[0];
      idx = $urandom_range(0, 15);
      a = {26'(idx >> 4), 4'(idx), 2'b00};
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      if (!w) begin
        e_d[i] = ref_mem[idx];
        last_rd = e_d[i];
      end else begin
        e_d[i] = last_rd;
        ref_write(a, wd, be);
      end
      req_i = 1'b1; we_i = w; be_i = be; addr_i = a; wdata_i = wd;
      #1;
      k = 0;
      while (!gnt_o && k < 20) begin @(negedge aclk); #1; k++; end
      chk("b2b:gnt", 32'(gnt_o), 32'd1);
      if (i > 0) chk("b2b:coinc", 32'(rvalid_o), 32'd1);
      @(posedge aclk); #1;
    end
    req_i = 1'b0; we_i = 1'b0;
    k = 0;
    while (rsp_n < n0 + 4 && k < 60) begin @(negedge aclk); #1; k++; end
    chk("b2b:count", 32'(rsp_n - n0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < rsp_n) begin
        chk("b2b:rdata", rsp_q[n0 + i][31:0], e_d[i]);
        chk("b2b:err", 32'(rsp_q[n0 + i][32]), 32'd0);
      end
    end
    chk("b2b:outstanding", 32'(max_out), 32'd1);

    r_err = 1'b1;
    txn(1'b0, 4'hF, 32'h0000_0030, '0, 3, "slverr");
    r_err = 1'b0;

    // instruction port: local fault on write
    @(negedge aclk);
    req2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 32'h40; wdata2 = 32'h1234;
    #1;
    chk("ifetch:gnt", 32'(gnt2), 32'd1);
    chk("ifetch:arprot", 32'(axi2.arprot), 32'd4);
    @(posedge aclk); #1;
    req2 = 1'b0; we2 = 1'b0;
    chk("ifetch:rvalid", 32'(rvalid2), 32'd1);
    chk("ifetch:err", 32'(err2), 32'd1);
    @(posedge aclk); #1;
    chk("ifetch:pulse", 32'(rvalid2), 32'd0);
    chk("ifetch:nobus", 32'(bus2_seen), 32'd0);
    chk("ifetch:count", 32'(rsp2_n), 32'd1);

    // reset while AR is pending
    ar_lat = 10;
    n0 = rsp_n;
    @(negedge aclk);
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h10;
    @(posedge aclk); #1;
    req_i = 1'b0;
    @(negedge aclk);
    chk("rstmid:arvalid_hi", 32'(axi.arvalid), 32'd1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("rstmid:arvalid_lo", 32'(axi.arvalid), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    ar_lat = 0;
    last_rd = '0;
    repeat (5) @(negedge aclk);
    #1;
    chk("rstmid:norsp", 32'(rsp_n - n0), 32'd0);
    txn(1'b0, 4'hF, 32'h0000_0010, '0, 3, "rstmid:read");

    for (int i = 0; i < 24; i++) begin
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3);
      b_err  = ($urandom_range(0, 5) == 0);
      r_err  = ($urandom_range(0, 5) == 0);
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom, -1, "rand");
    end
    chk("rand:viol", 32'(viol), 32'd0);
    chk("rand:outstanding", 32'(max_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
